// File: rtl/br_issue_ctrl_if.sv
// Issue/result bundle between the branch RS entries, the shared comparator and the CDB.
// master = RS/comparator/CDB side, slave = the scheduler.
interface br_issue_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int XLEN  = 32,
    parameter int ROB_W = 5
);
    logic                     flush;
    logic [ROB_W-1:0]         rob_head;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*ROB_W-1:0]   req_rob_idx;
    logic [N_REQ*3-1:0]       req_func;
    logic [N_REQ*XLEN-1:0]    req_rs1;
    logic [N_REQ*XLEN-1:0]    req_rs2;
    logic [N_REQ-1:0]         req_gnt;
    logic [2:0]               br_func;
    logic [XLEN-1:0]          br_rs1;
    logic [XLEN-1:0]          br_rs2;
    logic                     br_cond;
    logic                     res_valid;
    logic [ROB_W-1:0]         res_rob_idx;
    logic                     res_taken;
    logic                     cdb_gnt;

    modport master (
        output flush, rob_head, req_valid, req_rob_idx, req_func, req_rs1, req_rs2,
               br_cond, cdb_gnt,
        input  req_gnt, br_func, br_rs1, br_rs2, res_valid, res_rob_idx, res_taken
    );

    modport slave (
        input  flush, rob_head, req_valid, req_rob_idx, req_func, req_rs1, req_rs2,
               br_cond, cdb_gnt,
        output req_gnt, br_func, br_rs1, br_rs2, res_valid, res_rob_idx, res_taken
    );
endinterface

// File: rtl/br_issue_ctrl.sv
// Oldest-ready arbiter for the shared branch comparator; result registered, valid 1 cycle after grant.
// Grants stall while a held result waits for the CDB; a drain and refill may share one edge.
module br_issue_ctrl #(
    parameter int N_REQ = 4,
    parameter int XLEN  = 32,
    parameter int ROB_W = 5
) (
    input logic            clock,
    input logic            reset_n,
    br_issue_ctrl_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} res_state_e;

    res_state_e       state_q, state_d;
    logic [ROB_W-1:0] rob_q, rob_d;
    logic             taken_q, taken_d;

    logic             any_vld;
    logic [N_REQ-1:0] win_oh;
    logic [ROB_W-1:0] age, best_age, win_rob;
    logic [2:0]       win_func;
    logic [XLEN-1:0]  win_rs1, win_rs2;
    logic             can_issue, issue;

    // Age is distance from the ROB head; strict '<' keeps the lowest index on ties.
    always_comb begin
        any_vld  = 1'b0;
        win_oh   = '0;
        age      = '0;
        best_age = '0;
        win_rob  = '0;
        win_func = '0;
        win_rs1  = '0;
        win_rs2  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            age = bus.req_rob_idx[i*ROB_W +: ROB_W] - bus.rob_head;
            if (bus.req_valid[i] && (!any_vld || age < best_age)) begin
                any_vld   = 1'b1;
                best_age  = age;
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_rob   = bus.req_rob_idx[i*ROB_W +: ROB_W];
                win_func  = bus.req_func[i*3 +: 3];
                win_rs1   = bus.req_rs1[i*XLEN +: XLEN];
                win_rs2   = bus.req_rs2[i*XLEN +: XLEN];
            end
        end
    end

    assign can_issue = !bus.flush && (state_q == EMPTY || bus.cdb_gnt);
    assign issue     = reset_n && can_issue && any_vld;

    assign bus.req_gnt     = issue ? win_oh : '0;
    assign bus.br_func     = win_func;
    assign bus.br_rs1      = win_rs1;
    assign bus.br_rs2      = win_rs2;
    assign bus.res_valid   = (state_q == FULL);
    assign bus.res_rob_idx = rob_q;
    assign bus.res_taken   = taken_q;

    always_comb begin
        state_d = state_q;
        rob_d   = rob_q;
        taken_d = taken_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (issue) begin
            state_d = FULL;
            rob_d   = win_rob;
            taken_d = bus.br_cond;
        end else if (bus.cdb_gnt) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            rob_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rob_q   <= rob_d;
            taken_q <= taken_d;
        end
    end
endmodule

// File: tb/tb_br_issue_ctrl.sv
// Directed bench for br_issue_ctrl with a behavioural branch comparator on br_cond.
module tb_br_issue_ctrl;
    localparam int N = 4;
    localparam int XL = 32;
    localparam int RW = 5;

    logic clock;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    br_issue_ctrl_if #(.N_REQ(N), .XLEN(XL), .ROB_W(RW)) bus ();

    br_issue_ctrl #(.N_REQ(N), .XLEN(XL), .ROB_W(RW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference comparator: RISC-V func3 semantics, undefined codes give 0.
    always_comb begin
        case (bus.br_func)
            3'b000:  bus.br_cond = (bus.br_rs1 == bus.br_rs2);
            3'b001:  bus.br_cond = (bus.br_rs1 != bus.br_rs2);
            3'b100:  bus.br_cond = ($signed(bus.br_rs1) <  $signed(bus.br_rs2));
            3'b101:  bus.br_cond = ($signed(bus.br_rs1) >= $signed(bus.br_rs2));
            3'b110:  bus.br_cond = (bus.br_rs1 <  bus.br_rs2);
            3'b111:  bus.br_cond = (bus.br_rs1 >= bus.br_rs2);
            default: bus.br_cond = 1'b0;
        endcase
    end

    task automatic set_ent(input int i, input logic [RW-1:0] idx, input logic [2:0] f,
                           input logic [XL-1:0] a, input logic [XL-1:0] b);
        bus.req_rob_idx[i*RW +: RW] = idx;
        bus.req_func[i*3 +: 3]      = f;
        bus.req_rs1[i*XL +: XL]     = a;
        bus.req_rs2[i*XL +: XL]     = b;
    endtask

    task automatic drain();
        @(negedge clock);
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        bus.cdb_gnt   = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        bus.cdb_gnt   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.flush = 1'b0; bus.rob_head = '0; bus.req_valid = '0; bus.cdb_gnt = 1'b0;
        bus.req_rob_idx = '0; bus.req_func = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        #1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_init_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.req_gnt !== 4'b0000) begin n_err++; $display("FAIL rst_init_gnt: got %b want 0000", bus.req_gnt); end
        @(negedge clock);
        reset_n = 1'b1;
        set_ent(0, 5'd3, 3'b000, 32'd5, 32'd5);
        bus.req_valid = 4'b0001;
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", bus.res_valid); end
        #1;
        bus.cdb_gnt = 1'b1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.res_rob_idx !== 5'd0) begin n_err++; $display("FAIL rst_mid_idx: got %0d want 0", bus.res_rob_idx); end
        n_cmp++; if (bus.res_taken !== 1'b0) begin n_err++; $display("FAIL rst_mid_taken: got %b want 0", bus.res_taken); end
        n_cmp++; if (bus.req_gnt !== 4'b0000) begin n_err++; $display("FAIL rst_mid_gnt: got %b want 0000", bus.req_gnt); end
        @(negedge clock);
        reset_n = 1'b1;
        bus.req_valid = '0;
        bus.cdb_gnt = 1'b0;
    endtask

    task automatic test_wrap();
        @(negedge clock);
        bus.rob_head = 5'd30;
        set_ent(0, 5'd2,  3'b000, 32'd1, 32'd2);
        set_ent(1, 5'd31, 3'b000, 32'hAA, 32'hAA);
        set_ent(2, 5'd5,  3'b000, 32'd3, 32'd3);
        bus.req_valid = 4'b0111;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0010) begin n_err++; $display("FAIL wrap_gnt: got %b want 0010", bus.req_gnt); end
        n_cmp++; if (bus.br_rs1 !== 32'hAA) begin n_err++; $display("FAIL wrap_rs1: got %h want 000000aa", bus.br_rs1); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", bus.res_valid); end
        n_cmp++; if (bus.res_rob_idx !== 5'd31) begin n_err++; $display("FAIL wrap_idx: got %0d want 31", bus.res_rob_idx); end
        drain();
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        bus.rob_head = 5'd0;
        set_ent(0, 5'd4, 3'b100, 32'hFFFF_FFFF, 32'd1);
        set_ent(1, 5'd6, 3'b101, 32'd1, 32'd2);
        bus.req_valid = 4'b0001;
        bus.cdb_gnt = 1'b0;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0001) begin n_err++; $display("FAIL bp_first_gnt: got %b want 0001", bus.req_gnt); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_taken !== 1'b1) begin n_err++; $display("FAIL bp_blt: got valid=%b taken=%b want 1 1", bus.res_valid, bus.res_taken); end
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock); #1;
            n_cmp++; if (bus.req_gnt !== 4'b0000) begin n_err++; $display("FAIL bp_stall_gnt%0d: got %b want 0000", c, bus.req_gnt); end
            @(posedge clock); #1;
        end
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_rob_idx !== 5'd4) begin n_err++; $display("FAIL bp_hold: got valid=%b idx=%0d want 1 4", bus.res_valid, bus.res_rob_idx); end
        @(negedge clock);
        bus.cdb_gnt = 1'b1;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0010) begin n_err++; $display("FAIL bp_release_gnt: got %b want 0010", bus.req_gnt); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_rob_idx !== 5'd6 || bus.res_taken !== 1'b0) begin n_err++; $display("FAIL bp_refill: got valid=%b idx=%0d taken=%b want 1 6 0", bus.res_valid, bus.res_rob_idx, bus.res_taken); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_oh [4];
        logic [4:0] exp_idx [4];
        logic       exp_tk [4];
        exp_oh  = '{4'b1000, 4'b0010, 4'b0100, 4'b0001};
        exp_idx = '{5'd10, 5'd11, 5'd12, 5'd13};
        exp_tk  = '{1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clock);
        bus.rob_head = 5'd10;
        set_ent(0, 5'd13, 3'b111, 32'd0, 32'd1);
        set_ent(1, 5'd11, 3'b111, 32'd1, 32'd2);
        set_ent(2, 5'd12, 3'b111, 32'd5, 32'd5);
        set_ent(3, 5'd10, 3'b111, 32'hFFFF_FFFF, 32'd0);
        bus.req_valid = 4'b1111;
        bus.cdb_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (bus.req_gnt !== exp_oh[k]) begin n_err++; $display("FAIL stream_gnt%0d: got %b want %b", k, bus.req_gnt, exp_oh[k]); end
            @(posedge clock); #1;
            n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_rob_idx !== exp_idx[k] || bus.res_taken !== exp_tk[k]) begin n_err++; $display("FAIL stream_res%0d: got valid=%b idx=%0d taken=%b want 1 %0d %b", k, bus.res_valid, bus.res_rob_idx, bus.res_taken, exp_idx[k], exp_tk[k]); end
            bus.req_valid = bus.req_valid & ~exp_oh[k];
            @(negedge clock);
        end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", bus.res_valid); end
        drain();
    endtask

    task automatic test_flush();
        @(negedge clock);
        bus.rob_head = 5'd0;
        set_ent(0, 5'd9, 3'b000, 32'd0, 32'd0);
        set_ent(1, 5'd8, 3'b000, 32'd1, 32'd1);
        bus.req_valid = 4'b0001;
        bus.cdb_gnt = 1'b0;
        @(posedge clock); #1;
        bus.req_valid = 4'b0010;
        @(negedge clock);
        bus.flush = 1'b1;
        bus.cdb_gnt = 1'b1;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0000) begin n_err++; $display("FAIL flush_gnt: got %b want 0000", bus.req_gnt); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.res_valid); end
        @(negedge clock);
        bus.flush = 1'b0;
        bus.cdb_gnt = 1'b0;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0010) begin n_err++; $display("FAIL flush_after_gnt: got %b want 0010", bus.req_gnt); end
        drain();
    endtask

    task automatic test_tie_empty();
        @(negedge clock);
        bus.rob_head = 5'd0;
        set_ent(0, 5'd7, 3'b000, 32'd0, 32'd1);
        set_ent(1, 5'd7, 3'b001, 32'd3, 32'd4);
        set_ent(2, 5'd7, 3'b110, 32'd9, 32'd1);
        bus.req_valid = 4'b0110;
        bus.cdb_gnt = 1'b0;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0010) begin n_err++; $display("FAIL tie_gnt: got %b want 0010", bus.req_gnt); end
        n_cmp++; if (bus.br_func !== 3'b001) begin n_err++; $display("FAIL tie_func: got %b want 001", bus.br_func); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_rob_idx !== 5'd7 || bus.res_taken !== 1'b1) begin n_err++; $display("FAIL tie_res: got valid=%b idx=%0d taken=%b want 1 7 1", bus.res_valid, bus.res_rob_idx, bus.res_taken); end
        @(negedge clock);
        bus.req_valid = '0;
        #1;
        n_cmp++; if (bus.req_gnt !== 4'b0000 || bus.br_func !== 3'b000 || bus.br_rs1 !== 32'd0 || bus.br_rs2 !== 32'd0) begin n_err++; $display("FAIL empty_mux: got gnt=%b func=%b rs1=%h rs2=%h want 0000 000 0 0", bus.req_gnt, bus.br_func, bus.br_rs1, bus.br_rs2); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL empty_hold: got %b want 1", bus.res_valid); end
        @(negedge clock);
        bus.cdb_gnt = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL empty_drain: got %b want 0", bus.res_valid); end
        @(posedge clock); #1;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL empty_cdb_ignored: got %b want 0", bus.res_valid); end
        @(negedge clock);
        bus.cdb_gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_tie_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
